mult_booth_unit: RTL and testbench

- Multicycle signed 32x32 multiplier: radix-2 Booth, one iteration per clock. Serves MULT in the datapath.
- Sits directly upstream of the ALU-logic 4:1 result mux. Registered HI/LO drive two of its data inputs. The control unit selects them only after done.
- Start/busy/done handshake with the control unit; operands come from registers A and B.

---
 rtl/mult_pkg.sv | 19 +
 rtl/booth_step.sv | 34 +++
 rtl/mult_booth_unit.sv | 109 ++++++++++
 tb/tb_mult_booth_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier: FSM state encoding,
// Booth recoding constants for {Q[0],Q_1}, and the default operand width.
// No ports; imported by mult_booth_unit and booth_step.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth recoding of {Q[0], Q_1}; 2'b11 is also a no-op.
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub M per {q[0],q_1}, then arithmetic
// right shift of {acc,q,q_1}. Purely combinational, zero latency.
// Ports: acc/m (WIDTH+1), q (WIDTH), q_1 in; acc_nxt, q_nxt, q_1_nxt out.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_1_nxt
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            default:   sum = acc;
        endcase
    end

    // Arithmetic shift: sign bit of the accumulator is replicated.
    assign acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nxt   = {sum[0], q[WIDTH-1:1]};
    assign q_1_nxt = q[0];

endmodule

// File: rtl/mult_booth_unit.sv
// Multicycle signed WIDTHxWIDTH radix-2 Booth multiplier, one iteration/clock.
// Latency WIDTH+2 cycles start-to-done; start ignored unless IDLE (no queuing).
// Ports: clk, reset (async high), start, Data_A, Data_B in; busy, done, HI, LO out.
// Optional MULT_ZERO_SHORTCUT_EN: zero operand skips iteration (2-cycle latency).
module mult_booth_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Data_A,
    input  logic [WIDTH-1:0] Data_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    // ACC is one bit wider than the operands so that subtracting
    // M = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_1_nxt;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .q       (q),
        .q_1     (q_1),
        .m       (m),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt),
        .q_1_nxt (q_1_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= {Data_A[WIDTH-1], Data_A};
                        q   <= Data_B;
                        acc <= '0;
                        q_1 <= 1'b0;
                        cnt <= CNT_W'(WIDTH);
`ifdef MULT_ZERO_SHORTCUT_EN
                        if (Data_A == '0 || Data_B == '0) begin
                            q     <= '0;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`else
                        state <= RUN;
                        busy  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    q_1 <= q_1_nxt;
                    cnt <= cnt - CNT_W'(1);
                    // cnt==1 here means this is the last iteration.
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    // Product is the low 2*WIDTH bits of {ACC,Q}; ACC MSB is
                    // only a sign extension.
                    HI    <= acc[WIDTH-1:0];
                    LO    <= q;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_booth_unit.sv
module tb_mult_booth_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] Data_A;
    logic [31:0] Data_B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int passed;

    mult_booth_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Data_A (Data_A),
        .Data_B (Data_B),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    endtask

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_SHORTCUT_EN
        if (a == 32'd0 || b == 32'd0) return 2;
`endif
        return 34;
    endfunction

    // Issue one operation and check latency, busy length, product, pulse width, hold.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        int busyc;
        int elat;
        logic seen;
        logic [31:0] hi_s;
        lat = 0; busyc = 0; seen = 1'b0;
        elat = exp_latency(a, b);
        @(negedge clk);
        Data_A = a; Data_B = b; start = 1'b1;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (busy) busyc++;
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(elat));
        check({name, "_busy_cycles"}, 32'(busyc), (elat == 2) ? 32'd0 : 32'd32);
        check({name, "_hi"}, HI, ehi);
        check({name, "_lo"}, LO, elo);
        hi_s = HI;
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_hi_hold"}, HI, hi_s);
    endtask

    initial begin
        int lat;
        int ndone;
        int dlat;
        total = 0; passed = 0;

        vecs[0] = '{32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};
        vecs[4] = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800};
        vecs[7] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[9] = '{32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};

        reset = 1'b1; start = 1'b0; Data_A = '0; Data_B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Second start during RUN (with operand changes) must be ignored.
        @(negedge clk);
        Data_A = 32'd3; Data_B = 32'd4; start = 1'b1;
        lat = 0; ndone = 0; dlat = 0;
        while (lat < 45) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (lat == 10) begin
                start = 1'b1; Data_A = 32'd100; Data_B = 32'd100;
            end
            if (lat == 12) begin
                Data_A = 32'h55555555; Data_B = 32'hAAAAAAAA;
            end
            if (done) begin
                ndone++;
                if (dlat == 0) dlat = lat;
            end
        end
        check("ignore_done_count", 32'(ndone), 32'd1);
        check("ignore_latency", 32'(dlat), 32'd34);
        check("ignore_hi", HI, 32'd0);
        check("ignore_lo", LO, 32'd12);

        // Reset in the middle of RUN aborts immediately.
        @(negedge clk);
        Data_A = 32'd9; Data_B = 32'd9; start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("midrun_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrun_busy", 32'(busy), 32'd0);
        check("midrun_done", 32'(done), 32'd0);
        check("midrun_hi", HI, 32'd0);
        check("midrun_lo", LO, 32'd0);
        @(negedge clk);
        Data_A = 32'd5; Data_B = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        check("start_under_reset", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        lat = 0; ndone = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) ndone++;
        end
        check("no_done_after_abort", 32'(ndone), 32'd0);

        run_op("after_reset", 32'd5, 32'd6, 32'd0, 32'd30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
